// File: rtl/native2axil_adapter_pkg.sv
// rtl/native2axil_adapter_pkg.sv - AXI4-Lite constants and FSM state encoding for the native-to-AXI4-Lite adapter
//
// Purpose: shared definitions for native2axil_adapter.
//   AXI_RESP_W / AXI_PROT_W : AXI4-Lite response and protection field widths.
//   AXI_RESP_OKAY           : the only response code treated as success.
//   AXI_PROT_DEFAULT        : unprivileged, secure, data access.
//   state_t                 : 3-bit adapter FSM state.
package native2axil_adapter_pkg;

  localparam int AXI_RESP_W = 2;
  localparam int AXI_PROT_W = 3;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [AXI_PROT_W-1:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_ACK     = 3'd5
  } state_t;

endpackage

// File: rtl/native2axil_adapter.sv
// rtl/native2axil_adapter.sv - single-outstanding native request to AXI4-Lite master bridge
//
// Purpose: turns one native request (valid/addr/wdata/wstrb) into one AXI4-Lite
// read (wstrb == 0) or write (wstrb != 0) and answers with a one-cycle ready pulse.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid, addr, wdata, wstrb    native request, held by the master until ready
//   rdata, ready, err            native completion: ready pulses one cycle, err marks a non-OKAY response,
//                                rdata holds the last read data
//   m_axil_aw*/w*/b*             AXI4-Lite write address, write data and write response channels
//   m_axil_ar*/r*                AXI4-Lite read address and read data channels
module native2axil_adapter
  import native2axil_adapter_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [AXIL_ADDR_W-1:0]   addr,
  input  logic [AXIL_DATA_W-1:0]   wdata,
  input  logic [AXIL_DATA_W/8-1:0] wstrb,
  output logic [AXIL_DATA_W-1:0]   rdata,
  output logic                     ready,
  output logic                     err,
  output logic [AXIL_ADDR_W-1:0]   m_axil_awaddr,
  output logic [AXI_PROT_W-1:0]    m_axil_awprot,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [AXIL_DATA_W-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_W/8-1:0] m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [AXI_RESP_W-1:0]    m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic [AXIL_ADDR_W-1:0]   m_axil_araddr,
  output logic [AXI_PROT_W-1:0]    m_axil_arprot,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [AXIL_DATA_W-1:0]   m_axil_rdata,
  input  logic [AXI_RESP_W-1:0]    m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  state_t                 r_state,   w_state;
  logic [AXIL_ADDR_W-1:0] r_addr,    w_addr;
  logic [AXIL_DATA_W-1:0] r_wdata,   w_wdata;
  logic [STRB_W-1:0]      r_wstrb,   w_wstrb;
  logic [AXIL_DATA_W-1:0] r_rdata,   w_rdata;
  logic                   r_awvalid, w_awvalid;
  logic                   r_wvalid,  w_wvalid;
  logic                   r_bready,  w_bready;
  logic                   r_arvalid, w_arvalid;
  logic                   r_rready,  w_rready;
  logic                   r_ready,   w_ready;
  logic                   r_err,     w_err;
  logic                   r_aw_done, w_aw_done;
  logic                   r_w_done,  w_w_done;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;

  assign w_aw_hs = r_awvalid & m_axil_awready;
  assign w_w_hs  = r_wvalid  & m_axil_wready;
  assign w_b_hs  = r_bready  & m_axil_bvalid;
  assign w_ar_hs = r_arvalid & m_axil_arready;
  assign w_r_hs  = r_rready  & m_axil_rvalid;

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_wstrb   = r_wstrb;
    w_rdata   = r_rdata;
    w_awvalid = r_awvalid;
    w_wvalid  = r_wvalid;
    w_bready  = r_bready;
    w_arvalid = r_arvalid;
    w_rready  = r_rready;
    w_ready   = 1'b0;
    w_err     = r_err;
    w_aw_done = r_aw_done;
    w_w_done  = r_w_done;

    case (r_state)
      ST_IDLE: begin
        if (valid) begin
          // AXI payload comes from these copies so the master's live inputs
          // cannot disturb a channel that is already asserted.
          w_addr    = addr;
          w_wdata   = wdata;
          w_wstrb   = wstrb;
          w_aw_done = 1'b0;
          w_w_done  = 1'b0;
          if (wstrb != '0) begin
            w_state   = ST_WR_REQ;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else begin
            w_state   = ST_RD_REQ;
            w_arvalid = 1'b1;
          end
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently, in either order or together.
        if (w_aw_hs) w_awvalid = 1'b0;
        if (w_w_hs)  w_wvalid  = 1'b0;
        w_aw_done = r_aw_done | w_aw_hs;
        w_w_done  = r_w_done  | w_w_hs;
        if (w_aw_done && w_w_done) begin
          w_state  = ST_WR_RESP;
          w_bready = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (w_b_hs) begin
          w_bready = 1'b0;
          w_err    = (m_axil_bresp != AXI_RESP_OKAY);
          w_ready  = 1'b1;
          w_state  = ST_ACK;
        end
      end

      ST_RD_REQ: begin
        if (w_ar_hs) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (w_r_hs) begin
          w_rdata  = m_axil_rdata;
          w_err    = (m_axil_rresp != AXI_RESP_OKAY);
          w_rready = 1'b0;
          w_ready  = 1'b1;
          w_state  = ST_ACK;
        end
      end

      ST_ACK: begin
        // The master still holds the request it just completed, so valid is
        // not looked at here; err only accompanies the ready pulse.
        w_err   = 1'b0;
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_wstrb   <= w_wstrb;
      r_rdata   <= w_rdata;
      r_awvalid <= w_awvalid;
      r_wvalid  <= w_wvalid;
      r_bready  <= w_bready;
      r_arvalid <= w_arvalid;
      r_rready  <= w_rready;
      r_ready   <= w_ready;
      r_err     <= w_err;
      r_aw_done <= w_aw_done;
      r_w_done  <= w_w_done;
    end
  end

  assign rdata          = r_rdata;
  assign ready          = r_ready;
  assign err            = r_err;
  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = AXI_PROT_DEFAULT;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_native2axil_adapter.sv
// tb/tb_native2axil_adapter.sv - self-checking bench for native2axil_adapter
module tb_native2axil_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp = 2'b00;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata = 32'h0;
  logic [1:0]  m_axil_rresp = 2'b00;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;

  always #5 clk = ~clk;

  native2axil_adapter #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .err(err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
    .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // slave configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // reference model: which channel the bridge must be presenting next cycle
  logic        m_aw_pend = 0, m_w_pend = 0, m_ar_pend = 0;
  logic        m_busy = 0, m_ack = 0, m_exp_err = 0;
  logic [31:0] m_cur_addr = 0, m_cur_wdata = 0, m_last_rdata = 0;
  logic [3:0]  m_cur_wstrb = 0;
  logic        got_aw = 0, got_w = 0, got_ar = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

  // per-test statistics
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, br_hi = 0, rr_hi = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
  logic [3:0]  last_wstrb = 0;

  task automatic clr_stats();
    aw_hi = 0; w_hi = 0; ar_hi = 0; br_hi = 0; rr_hi = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
  endtask

  // Compare + slave process: everything here runs on the falling edge, where
  // DUT outputs are settled and slave inputs are set up for the next rising edge.
  initial begin
    logic b_fire, r_fire;
    forever begin
      @(negedge clk);
      chk("awvalid", m_axil_awvalid, m_aw_pend);
      chk("wvalid", m_axil_wvalid, m_w_pend);
      chk("arvalid", m_axil_arvalid, m_ar_pend);
      chk("bready", m_axil_bready, got_aw && got_w);
      chk("rready", m_axil_rready, got_ar);
      chk("ready", ready, m_ack);
      chk("rdata_hold", rdata, m_last_rdata);
      chk("awprot", m_axil_awprot, 3'b000);
      chk("arprot", m_axil_arprot, 3'b000);
      if (m_ack) chk("err", err, m_exp_err);
      if (m_aw_pend) chk("awaddr", m_axil_awaddr, m_cur_addr);
      if (m_w_pend) begin
        chk("wdata", m_axil_wdata, m_cur_wdata);
        chk("wstrb", m_axil_wstrb, m_cur_wstrb);
      end
      if (m_ar_pend) chk("araddr", m_axil_araddr, m_cur_addr);
      if (m_axil_awvalid === 1'b1) aw_hi++;
      if (m_axil_wvalid === 1'b1) w_hi++;
      if (m_axil_arvalid === 1'b1) ar_hi++;
      if (m_axil_bready === 1'b1) br_hi++;
      if (m_axil_rready === 1'b1) rr_hi++;

      if (rst) begin
        m_aw_pend = 0; m_w_pend = 0; m_ar_pend = 0; m_busy = 0; m_ack = 0;
        m_last_rdata = 0; got_aw = 0; got_w = 0; got_ar = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0;
      end else begin
        // responses only after the matching request handshakes have completed
        b_fire = got_aw && got_w && (b_wait >= b_delay);
        m_axil_bvalid = b_fire;
        m_axil_bresp  = b_fire ? cfg_bresp : 2'b11;
        if (got_aw && got_w) b_wait++;
        r_fire = got_ar && (r_wait >= r_delay);
        m_axil_rvalid = r_fire;
        m_axil_rdata  = r_fire ? cfg_rdata : 32'hBAD0_0BAD;
        m_axil_rresp  = r_fire ? cfg_rresp : 2'b11;
        if (got_ar) r_wait++;

        if (m_ack) begin
          m_ack = 0;
          m_busy = 0;
        end else if (!m_busy && valid) begin
          m_busy = 1;
          m_cur_addr = addr; m_cur_wdata = wdata; m_cur_wstrb = wstrb;
          if (wstrb != 4'h0) begin m_aw_pend = 1; m_w_pend = 1; end
          else m_ar_pend = 1;
        end

        if (b_fire && m_axil_bready) begin
          m_ack = 1; m_exp_err = (cfg_bresp != 2'b00);
          got_aw = 0; got_w = 0; b_wait = 0;
        end
        if (r_fire && m_axil_rready) begin
          m_ack = 1; m_exp_err = (cfg_rresp != 2'b00); m_last_rdata = cfg_rdata;
          got_ar = 0; r_wait = 0;
        end

        m_axil_awready = m_axil_awvalid && (aw_wait >= aw_delay);
        if (m_axil_awvalid && m_axil_awready) begin
          m_aw_pend = 0; got_aw = 1; aw_wait = 0; aw_cnt++; last_awaddr = m_axil_awaddr;
        end else if (m_axil_awvalid) aw_wait++;
        m_axil_wready = m_axil_wvalid && (w_wait >= w_delay);
        if (m_axil_wvalid && m_axil_wready) begin
          m_w_pend = 0; got_w = 1; w_wait = 0; w_cnt++;
          last_wdata = m_axil_wdata; last_wstrb = m_axil_wstrb;
        end else if (m_axil_wvalid) w_wait++;
        m_axil_arready = m_axil_arvalid && (ar_wait >= ar_delay);
        if (m_axil_arvalid && m_axil_arready) begin
          m_ar_pend = 0; got_ar = 1; ar_wait = 0; ar_cnt++; last_araddr = m_axil_araddr;
        end else if (m_axil_arvalid) ar_wait++;
      end
    end
  end

  task automatic wait_ready(output int lat, output logic [31:0] rd, output logic e);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ready !== 1'b1 && lat < 40);
    chk("ready_seen", ready, 1'b1);
    rd = rdata;
    e  = err;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output int lat, output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    valid = 1; addr = a; wdata = d; wstrb = s;
    wait_ready(lat, rd, e);
    if (!hold) begin
      valid = 0; addr = 0; wdata = 0; wstrb = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    rst = 1; valid = 0; addr = 0; wdata = 0; wstrb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_awvalid", m_axil_awvalid, 1'b0);
    chk("reset_arvalid", m_axil_arvalid, 1'b0);
    chk("reset_awaddr", m_axil_awaddr, 32'h0);
    rst = 0;

    // minimum-latency write
    clr_stats();
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, e);
    chk("t1_latency", lat, 3);
    chk("t1_err", e, 1'b0);
    chk("t1_aw_count", aw_cnt, 1);
    chk("t1_w_count", w_cnt, 1);
    chk("t1_ar_count", ar_cnt, 0);
    chk("t1_awaddr", last_awaddr, 32'h10);
    chk("t1_wdata", last_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", last_wstrb, 4'hF);

    // read with R three cycles late
    clr_stats();
    r_delay = 3; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    do_req(32'h20, 32'h0, 4'h0, 0, lat, rd, e);
    chk("t2_latency", lat, 6);
    chk("t2_rdata", rd, 32'h12345678);
    chk("t2_err", e, 1'b0);
    chk("t2_arvalid_cycles", ar_hi, 1);
    chk("t2_rready_cycles", rr_hi, 4);
    chk("t2_araddr", last_araddr, 32'h20);
    r_delay = 0;

    // W accepted four cycles late
    clr_stats();
    w_delay = 4;
    do_req(32'h104, 32'hA5A5_0001, 4'h3, 0, lat, rd, e);
    chk("t3a_latency", lat, 7);
    chk("t3a_awvalid_cycles", aw_hi, 1);
    chk("t3a_wvalid_cycles", w_hi, 5);
    chk("t3a_bready_cycles", br_hi, 1);
    w_delay = 0;

    // AW accepted four cycles late
    clr_stats();
    aw_delay = 4;
    do_req(32'h108, 32'h5A5A_0002, 4'hC, 0, lat, rd, e);
    chk("t3b_latency", lat, 7);
    chk("t3b_awvalid_cycles", aw_hi, 5);
    chk("t3b_wvalid_cycles", w_hi, 1);
    chk("t3b_bready_cycles", br_hi, 1);
    aw_delay = 0;

    // SLVERR read followed by an OKAY read
    cfg_rresp = 2'b10; cfg_rdata = 32'h0000_0E11;
    do_req(32'h200, 32'h0, 4'h0, 0, lat, rd, e);
    chk("t4_slverr_err", e, 1'b1);
    chk("t4_slverr_latency", lat, 3);
    cfg_rresp = 2'b00; cfg_rdata = 32'hCAFEF00D;
    do_req(32'h204, 32'h0, 4'h0, 0, lat, rd, e);
    chk("t4_okay_err", e, 1'b0);
    chk("t4_okay_rdata", rd, 32'hCAFEF00D);

    // valid held through ACK, next read presented immediately
    clr_stats();
    cfg_rdata = 32'h0F0F_1234;
    do_req(32'h30, 32'h0BADCAFE, 4'h1, 1, lat, rd, e);
    chk("t5_write_latency", lat, 3);
    addr = 32'h44; wdata = 0; wstrb = 0;
    wait_ready(lat, rd, e);
    valid = 0; addr = 0;
    chk("t5_read_latency", lat, 4);
    chk("t5_rdata", rd, 32'h0F0F_1234);
    chk("t5_aw_count", aw_cnt, 1);
    chk("t5_ar_count", ar_cnt, 1);
    chk("t5_araddr", last_araddr, 32'h44);

    // reset while the write address is still pending
    aw_delay = 10; w_delay = 10;
    @(posedge clk); #1;
    valid = 1; addr = 32'h80; wdata = 32'h55AA55AA; wstrb = 4'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_awvalid", m_axil_awvalid, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; valid = 0; addr = 0; wdata = 0; wstrb = 0;
    chk("t6_awvalid", m_axil_awvalid, 1'b0);
    chk("t6_wvalid", m_axil_wvalid, 1'b0);
    chk("t6_arvalid", m_axil_arvalid, 1'b0);
    chk("t6_ready", ready, 1'b0);
    chk("t6_bready", m_axil_bready, 1'b0);
    aw_delay = 0; w_delay = 0;
    clr_stats();
    do_req(32'h84, 32'h1357_9BDF, 4'hF, 0, lat, rd, e);
    chk("t6_after_latency", lat, 3);
    chk("t6_after_awaddr", last_awaddr, 32'h84);
    chk("t6_after_wdata", last_wdata, 32'h1357_9BDF);
    chk("t6_after_err", e, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
